seg_disp_ctrl: RTL

//  Scheduler for the 2-digit 7-segment display (Pmod SSD). It multiplexes one

---
 rtl/seg_disp_ctrl.sv | 90 +++++++++
 1 files changed

// File: rtl/seg_disp_ctrl.sv
// seg_disp_ctrl: 2-digit 7-segment scanner with frame-aligned value commits, blink and leading-zero blanking
module seg_disp_ctrl #(
  parameter int REFRESH_DIV  = 125000,
  parameter int BLINK_FRAMES = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [7:0] load_data,
  input  logic       blink_en,
  input  logic       blank_lz,
  output logic       digit_select,
  output logic [6:0] seg_led,
  output logic       frame_done
);
  localparam int RW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  typedef enum logic {IDLE, PENDING} state_t;
  state_t r_state, w_state_nxt;
  logic [RW-1:0] r_rcnt;
  logic [BW-1:0] r_bcnt, w_bcnt_nxt;
  logic r_phase, w_phase_nxt, w_wrap, w_frame, w_sel_nxt, w_commit, w_bwrap;
  logic [7:0] r_shadow, r_disp, w_disp_nxt;
  logic [3:0] w_nib;
  logic [6:0] w_seg_nxt;
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction
  assign w_wrap     = r_rcnt == RW'(REFRESH_DIV - 1);
  assign w_frame    = w_wrap & digit_select;
  assign w_sel_nxt  = ~digit_select;
  assign load_ready = r_state == IDLE;
  assign w_commit   = (r_state == PENDING) & w_frame;
  assign w_bwrap    = r_bcnt == BW'(BLINK_FRAMES - 1);
  // The segment register is decoded from next-cycle select, display and phase
  // so a slot never starts with stale content.
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == IDLE && load_valid) w_state_nxt = PENDING;
    else if (w_commit) w_state_nxt = IDLE;
    w_disp_nxt  = w_commit ? r_shadow : r_disp;
    w_bcnt_nxt  = !blink_en ? '0 : !w_frame ? r_bcnt : w_bwrap ? '0 : r_bcnt + 1'b1;
    w_phase_nxt = blink_en & (r_phase ^ (w_frame & w_bwrap));
    w_nib       = w_sel_nxt ? w_disp_nxt[7:4] : w_disp_nxt[3:0];
    w_seg_nxt   = ((blink_en && w_phase_nxt) || (w_sel_nxt && blank_lz && w_nib == 4'h0)) ? 7'h00 : hex7(w_nib);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_rcnt       <= '0;
      r_bcnt       <= '0;
      r_phase      <= 1'b0;
      r_shadow     <= 8'h00;
      r_disp       <= 8'h00;
      digit_select <= 1'b0;
      seg_led      <= 7'h00;
      frame_done   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rcnt     <= w_wrap ? '0 : r_rcnt + 1'b1;
      r_bcnt     <= w_bcnt_nxt;
      r_phase    <= w_phase_nxt;
      r_disp     <= w_disp_nxt;
      frame_done <= w_frame;
      if (r_state == IDLE && load_valid) r_shadow <= load_data;
      if (w_wrap) begin
        digit_select <= w_sel_nxt;
        seg_led      <= w_seg_nxt;
      end
    end
  end
endmodule
